// File: rtl/ecc_16_rd_check.sv
// ecc_16_rd_check
// Read-side SECDED check/correct stage for the ECC-protected FIFO. Consumes
// the stored {data,parity} word from the FIFO read port, recomputes parity,
// corrects single-bit data errors and flags uncorrectable (double) errors.
// Two-stage valid/ready pipeline: stage 1 holds data/syndrome/addr/bypass,
// stage 2 holds the corrected word and its error flags.
//
// Optional feature macro: ECC_ERR_CNT_EN
//   defined   -> saturating sbit/dbit error counters are implemented
//   undefined -> no counter flops, sbit_cnt/dbit_cnt tied to 0
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   s_valid/s_ready          input handshake (s_ready is combinational)
//   s_data/s_parity/s_addr   stored word, its check bits, FIFO read address
//   bypass                   pass data untouched, no error reporting
//   m_valid/m_ready          output handshake
//   m_data                   corrected data
//   m_sbit_err/m_dbit_err    per-word error flags (qualified by m_valid)
//   clr_stat                 pulse: clear sticky flags, counters, dbit_addr
//   sbit_sticky/dbit_sticky  sticky error flags
//   dbit_addr                address of the first dbit error since clear
//   sbit_cnt/dbit_cnt        saturating delivered-error counters
module ecc_16_rd_check #(
  parameter int DATA_WIDTH   = 16,
  parameter int PARITY_WIDTH = 6,
  parameter int ADDR_W       = 8,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic [PARITY_WIDTH-1:0] s_parity,
  input  logic [ADDR_W-1:0]       s_addr,
  input  logic                    bypass,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_sbit_err,
  output logic                    m_dbit_err,
  input  logic                    clr_stat,
  output logic                    sbit_sticky,
  output logic                    dbit_sticky,
  output logic [ADDR_W-1:0]       dbit_addr,
  output logic [CNT_W-1:0]        sbit_cnt,
  output logic [CNT_W-1:0]        dbit_cnt
);

  function automatic logic [5:0] ecc_encode(input logic [15:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[11]^d[13]^d[15];
    p[1] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[10]^d[12]^d[13];
    p[2] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[10]^d[14]^d[15];
    p[3] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[10];
    p[4] = d[11]^d[12]^d[13]^d[14]^d[15];
    p[5] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[12]^d[14];
    return p;
  endfunction

  // ---------------- pipeline control ----------------
  logic v1_q, v2_q;
  logic ld2;

  assign ld2     = !v2_q || m_ready;
  assign s_ready = !v1_q || ld2;

  // ---------------- stage 1 ----------------
  logic [DATA_WIDTH-1:0]   d1_q;
  logic [PARITY_WIDTH-1:0] syn1_q;
  logic [ADDR_W-1:0]       a1_q;
  logic                    byp1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      d1_q   <= '0;
      syn1_q <= '0;
      a1_q   <= '0;
      byp1_q <= 1'b0;
    end else if (s_ready) begin
      v1_q <= s_valid;
      if (s_valid) begin
        d1_q   <= s_data;
        syn1_q <= s_parity ^ ecc_encode(s_data);
        a1_q   <= s_addr;
        byp1_q <= bypass;
      end
    end
  end

  // ---------------- syndrome decode ----------------
  logic [DATA_WIDTH-1:0] corr_d;
  logic                  sb_d, db_d, col_hit;

  always_comb begin
    corr_d  = d1_q;
    sb_d    = 1'b0;
    db_d    = 1'b0;
    col_hit = 1'b0;
    // Syndrome matching a data column -> flip that data bit.
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (syn1_q == ecc_encode(DATA_WIDTH'(1) << i)) begin
        corr_d[i] = ~d1_q[i];
        col_hit   = 1'b1;
      end
    end
    if (syn1_q != '0) begin
      // One-hot syndrome is a flipped check bit: data is already right.
      if (col_hit || ((syn1_q & (syn1_q - PARITY_WIDTH'(1))) == '0))
        sb_d = 1'b1;
      else
        db_d = 1'b1;
    end
    if (!col_hit || db_d || byp1_q) corr_d = d1_q;
    if (byp1_q) begin
      sb_d = 1'b0;
      db_d = 1'b0;
    end
  end

  // ---------------- stage 2 ----------------
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  m_sb_q, m_db_q;
  logic [ADDR_W-1:0]     a2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q     <= 1'b0;
      m_data_q <= '0;
      m_sb_q   <= 1'b0;
      m_db_q   <= 1'b0;
      a2_q     <= '0;
    end else if (ld2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        m_data_q <= corr_d;
        m_sb_q   <= sb_d;
        m_db_q   <= db_d;
        a2_q     <= a1_q;
      end
    end
  end

  assign m_valid    = v2_q;
  assign m_data     = m_data_q;
  assign m_sbit_err = m_sb_q;
  assign m_dbit_err = m_db_q;

  // ---------------- status ----------------
  // Status counts words as they are delivered, so a stalled word counts once.
  logic hs, sb_hit, db_hit;
  assign hs     = v2_q && m_ready;
  assign sb_hit = hs && m_sb_q;
  assign db_hit = hs && m_db_q;

  logic              sbit_sticky_q, sbit_sticky_d;
  logic              dbit_sticky_q, dbit_sticky_d;
  logic [ADDR_W-1:0] dbit_addr_q, dbit_addr_d;

  // Clear first, then let a same-cycle error register on top of it.
  always_comb begin
    sbit_sticky_d = (clr_stat ? 1'b0 : sbit_sticky_q) | sb_hit;
    dbit_sticky_d = (clr_stat ? 1'b0 : dbit_sticky_q) | db_hit;
    dbit_addr_d   = clr_stat ? '0 : dbit_addr_q;
    if (db_hit && (!dbit_sticky_q || clr_stat)) dbit_addr_d = a2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sbit_sticky_q <= 1'b0;
      dbit_sticky_q <= 1'b0;
      dbit_addr_q   <= '0;
    end else begin
      sbit_sticky_q <= sbit_sticky_d;
      dbit_sticky_q <= dbit_sticky_d;
      dbit_addr_q   <= dbit_addr_d;
    end
  end

  assign sbit_sticky = sbit_sticky_q;
  assign dbit_sticky = dbit_sticky_q;
  assign dbit_addr   = dbit_addr_q;

`ifdef ECC_ERR_CNT_EN
  logic [CNT_W-1:0] sbit_cnt_q, sbit_cnt_d;
  logic [CNT_W-1:0] dbit_cnt_q, dbit_cnt_d;

  always_comb begin
    sbit_cnt_d = clr_stat ? '0 : sbit_cnt_q;
    dbit_cnt_d = clr_stat ? '0 : dbit_cnt_q;
    if (sb_hit && (sbit_cnt_d != '1)) sbit_cnt_d = sbit_cnt_d + CNT_W'(1);
    if (db_hit && (dbit_cnt_d != '1)) dbit_cnt_d = dbit_cnt_d + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sbit_cnt_q <= '0;
      dbit_cnt_q <= '0;
    end else begin
      sbit_cnt_q <= sbit_cnt_d;
      dbit_cnt_q <= dbit_cnt_d;
    end
  end

  assign sbit_cnt = sbit_cnt_q;
  assign dbit_cnt = dbit_cnt_q;
`else
  assign sbit_cnt = '0;
  assign dbit_cnt = '0;
`endif

endmodule

// File: tb/tb_ecc_16_rd_check.sv
// Randomized + directed bench for ecc_16_rd_check with a queue scoreboard
// and a reference decoder that searches for the nearest codeword.
module tb_ecc_16_rd_check;

  localparam int CW = 4;
`ifdef ECC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready;
  logic [15:0]   s_data;
  logic [5:0]    s_parity;
  logic [7:0]    s_addr;
  logic          bypass;
  logic          m_valid, m_ready;
  logic [15:0]   m_data;
  logic          m_sbit_err, m_dbit_err;
  logic          clr_stat;
  logic          sbit_sticky, dbit_sticky;
  logic [7:0]    dbit_addr;
  logic [CW-1:0] sbit_cnt, dbit_cnt;

  always #5 clk = ~clk;

  ecc_16_rd_check #(.DATA_WIDTH(16), .PARITY_WIDTH(6), .ADDR_W(8), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_parity(s_parity),
    .s_addr(s_addr), .bypass(bypass),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sbit_err(m_sbit_err), .m_dbit_err(m_dbit_err),
    .clr_stat(clr_stat), .sbit_sticky(sbit_sticky), .dbit_sticky(dbit_sticky),
    .dbit_addr(dbit_addr), .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  function automatic logic [5:0] enc(input logic [15:0] d);
    logic [5:0] p;
    p[0] = ^(d & 16'hAD5B);
    p[1] = ^(d & 16'h366D);
    p[2] = ^(d & 16'hC78E);
    p[3] = ^(d & 16'h07F0);
    p[4] = ^(d & 16'hF800);
    p[5] = ^(d & 16'h5CB7);
    return p;
  endfunction

  // Nearest-codeword decode: clean, one flipped check bit, one flipped data
  // bit (found by trial re-encoding), otherwise uncorrectable.
  function automatic void ref_decode(input logic [15:0] d, input logic [5:0] p,
                                     input bit byp, output logic [15:0] od,
                                     output bit sb, output bit db);
    logic [5:0] syn;
    syn = p ^ enc(d);
    od = d; sb = 1'b0; db = 1'b0;
    if (byp || syn == 6'd0) return;
    if ($countones(syn) == 1) begin sb = 1'b1; return; end
    for (int i = 0; i < 16; i++) begin
      if (enc(d ^ (16'h1 << i)) == p) begin
        od = d ^ (16'h1 << i); sb = 1'b1; return;
      end
    end
    db = 1'b1;
  endfunction

  bit         e_ss, e_ds;
  logic [7:0] e_da;
  int         e_sc, e_dc;

  task automatic model_clear();
    e_ss = 0; e_ds = 0; e_da = 8'h00; e_sc = 0; e_dc = 0;
  endtask

  task automatic model_status(input bit sb, input bit db, input logic [7:0] a, input bit clr);
    if (clr) model_clear();
    if (sb) begin e_ss = 1; if (e_sc < 15) e_sc++; end
    if (db) begin
      if (!e_ds) e_da = a;
      e_ds = 1;
      if (e_dc < 15) e_dc++;
    end
  endtask

  function automatic logic [CW-1:0] exp_cnt(input int c);
    return CNT_EN ? CW'(c) : CW'(0);
  endfunction

  typedef struct { logic [15:0] d; bit sb; bit db; } exp_t;

  // ---------------- drive helpers (no checking) ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1; s_valid = 0; m_ready = 0; clr_stat = 0; bypass = 0;
    s_data = '0; s_parity = '0; s_addr = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    model_clear();
  endtask

  // Push one word into an empty pipeline with m_ready=1 and capture it.
  task automatic send_one(input logic [15:0] d, input logic [5:0] p, input logic [7:0] a,
                          input bit byp, input bit clr,
                          output logic [15:0] od, output bit osb, output bit odb,
                          output int lat, output bit ok);
    @(negedge clk);
    s_valid = 1; s_data = d; s_parity = p; s_addr = a; bypass = byp; m_ready = 1;
    @(negedge clk);
    s_valid = 0; bypass = 0;
    lat = 1;
    while (!m_valid && lat < 10) begin @(negedge clk); lat++; end
    ok = m_valid; od = m_data; osb = m_sbit_err; odb = m_dbit_err;
    if (ok) begin
      clr_stat = clr;
      @(negedge clk);
      clr_stat = 0;
    end
  endtask

  task automatic gen_word(input int kind, output logic [15:0] d, output logic [5:0] p);
    logic [15:0] g;
    int i, j;
    g = 16'($urandom); d = g; p = enc(g);
    i = $urandom_range(0, 15);
    j = (i + 1 + $urandom_range(0, 14)) % 16;
    case (kind)
      1: d = g ^ (16'h1 << i);
      2: p = p ^ (6'h1 << $urandom_range(0, 5));
      3: d = g ^ (16'h1 << i) ^ (16'h1 << j);
      default: ;
    endcase
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    total++; if (m_data !== 16'h0 || m_sbit_err !== 1'b0 || m_dbit_err !== 1'b0) begin bad++;
      $display("FAIL reset_m_out got=%h/%b/%b exp=0000/0/0", m_data, m_sbit_err, m_dbit_err); end
    total++; if (sbit_sticky !== 1'b0 || dbit_sticky !== 1'b0 || dbit_addr !== 8'h00 ||
                 sbit_cnt !== '0 || dbit_cnt !== '0) begin bad++;
      $display("FAIL reset_status got=%b %b %h %h %h exp=all zero", sbit_sticky, dbit_sticky, dbit_addr, sbit_cnt, dbit_cnt); end
    total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
  endtask

  task automatic test_clean();
    logic [15:0] od; bit sb, db, ok; int lat;
    send_one(16'hA5A5, enc(16'hA5A5), 8'h01, 0, 0, od, sb, db, lat, ok);
    total++; if (!ok || lat != 2) begin bad++; $display("FAIL clean_latency got=%0d ok=%b exp=2", lat, ok); end
    total++; if (od !== 16'hA5A5 || sb || db) begin bad++;
      $display("FAIL clean_word got=%h/%b/%b exp=a5a5/0/0", od, sb, db); end
  endtask

  task automatic test_sbit();
    logic [15:0] od; bit sb, db, ok; int lat;
    send_one(16'hA5A5 ^ 16'h0008, enc(16'hA5A5), 8'h02, 0, 0, od, sb, db, lat, ok);
    model_status(1, 0, 8'h02, 0);
    total++; if (!ok || od !== 16'hA5A5 || sb !== 1'b1 || db !== 1'b0) begin bad++;
      $display("FAIL sbit_word got=%h/%b/%b exp=a5a5/1/0", od, sb, db); end
    total++; if (sbit_sticky !== 1'b1 || sbit_cnt !== exp_cnt(1)) begin bad++;
      $display("FAIL sbit_status got=%b/%h exp=1/%h", sbit_sticky, sbit_cnt, exp_cnt(1)); end
  endtask

  task automatic test_dbit();
    logic [15:0] od; bit sb, db, ok; int lat;
    send_one(16'hA5A5 ^ 16'h0003, enc(16'hA5A5), 8'h3C, 0, 0, od, sb, db, lat, ok);
    model_status(0, 1, 8'h3C, 0);
    total++; if (!ok || od !== 16'hA5A6 || sb !== 1'b0 || db !== 1'b1) begin bad++;
      $display("FAIL dbit_word got=%h/%b/%b exp=a5a6/0/1", od, sb, db); end
    total++; if (dbit_sticky !== 1'b1 || dbit_addr !== 8'h3C) begin bad++;
      $display("FAIL dbit_first_addr got=%b/%h exp=1/3c", dbit_sticky, dbit_addr); end
    send_one(16'hA5A5 ^ 16'h0003, enc(16'hA5A5), 8'h40, 0, 0, od, sb, db, lat, ok);
    model_status(0, 1, 8'h40, 0);
    total++; if (dbit_addr !== 8'h3C || dbit_cnt !== exp_cnt(2)) begin bad++;
      $display("FAIL dbit_second got=%h/%h exp=3c/%h", dbit_addr, dbit_cnt, exp_cnt(2)); end
  endtask

  task automatic test_bypass_clear();
    logic [15:0] od; bit sb, db, ok; int lat;
    send_one(16'hA5A5, enc(16'hA5A5) ^ 6'h01, 8'h11, 1, 0, od, sb, db, lat, ok);
    total++; if (!ok || od !== 16'hA5A5 || sb || db) begin bad++;
      $display("FAIL bypass_word got=%h/%b/%b exp=a5a5/0/0", od, sb, db); end
    total++; if (sbit_sticky !== e_ss || dbit_sticky !== e_ds || sbit_cnt !== exp_cnt(e_sc) ||
                 dbit_cnt !== exp_cnt(e_dc) || dbit_addr !== e_da) begin bad++;
      $display("FAIL bypass_status got=%b %b %h %h %h exp=%b %b %h %h %h", sbit_sticky, dbit_sticky,
               sbit_cnt, dbit_cnt, dbit_addr, e_ss, e_ds, exp_cnt(e_sc), exp_cnt(e_dc), e_da); end
    // Clear coinciding with an sbit handshake.
    send_one(16'h1234 ^ 16'h0100, enc(16'h1234), 8'h22, 0, 1, od, sb, db, lat, ok);
    model_status(1, 0, 8'h22, 1);
    total++; if (!ok || od !== 16'h1234 || sb !== 1'b1) begin bad++;
      $display("FAIL clr_word got=%h/%b exp=1234/1", od, sb); end
    total++; if (sbit_sticky !== 1'b1 || sbit_cnt !== exp_cnt(1) || dbit_sticky !== 1'b0 ||
                 dbit_cnt !== '0 || dbit_addr !== 8'h00) begin bad++;
      $display("FAIL clr_status got=%b %h %b %h %h exp=1 %h 0 0 00", sbit_sticky, sbit_cnt,
               dbit_sticky, dbit_cnt, dbit_addr, exp_cnt(1)); end
  endtask

  // Streaming scenario: rnd=0 is the fixed 1,0,0 m_ready pattern with
  // continuous s_valid; rnd=1 randomizes both sides, errors and bypass.
  task automatic test_backpressure(input int nwords, input bit rnd);
    exp_t q[$];
    exp_t e, w;
    int sent, got, cyc;
    bit prev_stall, full_seen, exp_rdy;
    logic [15:0] prev_d, d, od;
    logic [5:0] p;
    bit sb, db, byp;
    sent = 0; got = 0; cyc = 0; prev_stall = 0; full_seen = 0; prev_d = '0;
    while (got < nwords && cyc < 3000) begin
      @(negedge clk);
      if (sent < nwords) begin
        s_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        gen_word(rnd ? $urandom_range(0, 3) : (sent % 4), d, p);
        byp = rnd && ($urandom_range(0, 7) == 0);
        s_data = d; s_parity = p; bypass = byp; s_addr = 8'(sent);
      end else begin
        s_valid = 0; byp = 0; bypass = 0;
      end
      m_ready = rnd ? 1'($urandom_range(0, 1)) : (cyc % 3 == 0);
      #1;
      if (prev_stall) begin
        total++;
        if (m_valid !== 1'b1 || m_data !== prev_d) begin bad++;
          $display("FAIL stall_hold cyc=%0d got=%b/%h exp=1/%h", cyc, m_valid, m_data, prev_d); end
      end
      exp_rdy = (q.size() < 2) || m_ready;
      total++;
      if (s_ready !== exp_rdy) begin bad++;
        $display("FAIL s_ready cyc=%0d got=%b exp=%b", cyc, s_ready, exp_rdy); end
      if (!s_ready) full_seen = 1;
      if (m_valid && m_ready) begin
        total++;
        if (q.size() == 0) begin bad++; $display("FAIL extra_word cyc=%0d got=%h exp=none", cyc, m_data); end
        else begin
          w = q.pop_front();
          if (m_data !== w.d || m_sbit_err !== w.sb || m_dbit_err !== w.db) begin bad++;
            $display("FAIL stream_word n=%0d got=%h/%b/%b exp=%h/%b/%b", got, m_data,
                     m_sbit_err, m_dbit_err, w.d, w.sb, w.db); end
          model_status(w.sb, w.db, 8'(got), 0);
        end
        got++;
      end
      if (s_valid && s_ready) begin
        ref_decode(d, p, byp, od, sb, db);
        e.d = od; e.sb = sb; e.db = db;
        q.push_back(e);
        sent++;
      end
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      cyc++;
    end
    total++;
    if (got != nwords) begin bad++; $display("FAIL stream_timeout got=%0d exp=%0d", got, nwords); end
    @(negedge clk); s_valid = 0; m_ready = 1; bypass = 0;
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL stream_dup got=%b exp=0", m_valid); end
    if (!rnd) begin
      total++;
      if (!full_seen) begin bad++; $display("FAIL full_stall got=%b exp=1", full_seen); end
    end
    total++;
    if (sbit_sticky !== e_ss || dbit_sticky !== e_ds || dbit_addr !== e_da ||
        sbit_cnt !== exp_cnt(e_sc) || dbit_cnt !== exp_cnt(e_dc)) begin bad++;
      $display("FAIL stream_status got=%b %b %h %h %h exp=%b %b %h %h %h", sbit_sticky, dbit_sticky,
               dbit_addr, sbit_cnt, dbit_cnt, e_ss, e_ds, e_da, exp_cnt(e_sc), exp_cnt(e_dc)); end
  endtask

  task automatic test_saturation_reset();
    logic [15:0] d; logic [5:0] p;
    int vcount;
    do_reset();
    m_ready = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      gen_word(1, d, p);
      s_valid = 1; s_data = d; s_parity = p; s_addr = 8'(i);
      model_status(1, 0, 8'(i), 0);
    end
    @(negedge clk); s_valid = 0;
    repeat (3) @(negedge clk);
    total++;
    if (sbit_cnt !== exp_cnt(e_sc) || e_sc != 15 || sbit_sticky !== 1'b1) begin bad++;
      $display("FAIL sat_cnt got=%h/%b exp=%h/1", sbit_cnt, sbit_sticky, exp_cnt(15)); end
    // Reset with words in flight.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      gen_word(3, d, p);
      s_valid = 1; s_data = d; s_parity = p;
    end
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || sbit_cnt !== '0 || dbit_cnt !== '0 || sbit_sticky !== 1'b0 ||
        dbit_sticky !== 1'b0) begin bad++;
      $display("FAIL rst_mid got=%b %h %h %b %b exp=0 0 0 0 0", m_valid, sbit_cnt, dbit_cnt,
               sbit_sticky, dbit_sticky); end
    rst = 0; s_valid = 0;
    model_clear();
    vcount = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (m_valid) vcount++;
    end
    total++;
    if (vcount != 0) begin bad++; $display("FAIL rst_discard got=%0d exp=0", vcount); end
  endtask

  initial begin
    rst = 1; s_valid = 0; m_ready = 0; clr_stat = 0; bypass = 0;
    s_data = '0; s_parity = '0; s_addr = '0;
    test_reset();
    test_clean();
    test_sbit();
    test_dbit();
    test_bypass_clear();
    test_backpressure(8, 0);
    test_backpressure(300, 1);
    test_saturation_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
